// File: rtl/debug_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : debug_cmd_ctrl_if
// Brief    : Handshake/bus bundle between the debug command controller, the
//            UART RX FIFO, the pipeline and the TX dump logic.
// Revision : 1.0 - initial release
// ============================================================================
interface debug_cmd_ctrl_if #(
   parameter int PC_WIDTH = 32
);
   logic [7:0]          r_data;
   logic                rx_ready;
   logic                rd_uart;
   logic                program_finished;
   logic [PC_WIDTH-1:0] pc;
   logic                data_sent;
   logic                send_signal;
   logic [7:0]          status_code;
   logic                pipeline_clk_en;
   logic                pipeline_reset;
   logic [3:0]          current_state;

   modport master (
      input  r_data, rx_ready, program_finished, pc, data_sent,
      output rd_uart, send_signal, status_code, pipeline_clk_en,
             pipeline_reset, current_state
   );

   modport slave (
      output r_data, rx_ready, program_finished, pc, data_sent,
      input  rd_uart, send_signal, status_code, pipeline_clk_en,
             pipeline_reset, current_state
   );
endinterface
`default_nettype wire

// File: rtl/debug_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : debug_cmd_ctrl
// Brief    : UART debug command decoder gating the pipeline clock for step,
//            run, soft reset and (with BREAKPOINT_EN) breakpoint commands.
// Revision : 1.0 - initial release
// ============================================================================
module debug_cmd_ctrl #(
   parameter int PC_WIDTH      = 32,
   parameter int TIMEOUT_WIDTH = 24,
   parameter int RESET_CYCLES  = 2
) (
   input logic              clock,
   input logic              reset,
   debug_cmd_ctrl_if.master bus
);

   localparam logic [3:0] c_ST_INIT       = 4'd0;
   localparam logic [3:0] c_ST_WAITING    = 4'd1;
   localparam logic [3:0] c_ST_ARG_RX     = 4'd2;
   localparam logic [3:0] c_ST_STEP       = 4'd3;
   localparam logic [3:0] c_ST_RUN        = 4'd4;
   localparam logic [3:0] c_ST_SOFT_RESET = 4'd5;
   localparam logic [3:0] c_ST_UNKNOWN    = 4'd6;
   localparam logic [3:0] c_ST_SENDING    = 4'd7;

   localparam logic [1:0] c_PH_IDLE  = 2'd0;
   localparam logic [1:0] c_PH_POP   = 2'd1;
   localparam logic [1:0] c_PH_GUARD = 2'd2;

   localparam logic [8:0] c_RST_CYC = 9'(RESET_CYCLES);

   logic [3:0]               state_q,  state_d;
   logic [1:0]               phase_q,  phase_d;
   logic [7:0]               byte_q,   byte_d;
   logic [8:0]               cnt_q,    cnt_d;
   logic [TIMEOUT_WIDTH-1:0] tmo_q,    tmo_d;
   logic [7:0]               status_q, status_d;
   logic                     rd_uart_q, rd_uart_d;
   logic                     send_q,    send_d;
   logic                     clk_en_q,  clk_en_d;
   logic                     prst_q,    prst_d;

`ifdef BREAKPOINT_EN
   localparam logic [8:0] c_ARG_BYTES = 9'(PC_WIDTH / 8);

   logic [PC_WIDTH-1:0] bp_q, bp_d;
   logic                bp_valid_q, bp_valid_d;
   logic                arg_bp_q, arg_bp_d;
`else
   logic w_unused_pc;
   assign w_unused_pc = ^bus.pc;
`endif

   // State and all registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= c_ST_INIT;
         phase_q   <= c_PH_IDLE;
         byte_q    <= 8'h00;
         cnt_q     <= 9'd0;
         tmo_q     <= '0;
         status_q  <= 8'h00;
         rd_uart_q <= 1'b0;
         send_q    <= 1'b0;
         clk_en_q  <= 1'b0;
         prst_q    <= 1'b1;
`ifdef BREAKPOINT_EN
         bp_q       <= '0;
         bp_valid_q <= 1'b0;
         arg_bp_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         byte_q    <= byte_d;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
         status_q  <= status_d;
         rd_uart_q <= rd_uart_d;
         send_q    <= send_d;
         clk_en_q  <= clk_en_d;
         prst_q    <= prst_d;
`ifdef BREAKPOINT_EN
         bp_q       <= bp_d;
         bp_valid_q <= bp_valid_d;
         arg_bp_q   <= arg_bp_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      byte_d   = byte_q;
      cnt_d    = cnt_q;
      tmo_d    = tmo_q;
      status_d = status_q;
`ifdef BREAKPOINT_EN
      bp_d       = bp_q;
      bp_valid_d = bp_valid_q;
      arg_bp_d   = arg_bp_q;
`endif
      case (state_q)
         c_ST_INIT: begin
            if (cnt_q == c_RST_CYC) begin
               state_d = c_ST_WAITING;
               cnt_d   = 9'd0;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         c_ST_WAITING, c_ST_ARG_RX: begin
            // Each byte: latch + pop, one guard cycle, then act on it
            case (phase_q)
               c_PH_IDLE: begin
                  if (bus.rx_ready) begin
                     byte_d  = bus.r_data;
                     phase_d = c_PH_POP;
                  end
               end
               c_PH_POP: phase_d = c_PH_GUARD;
               default: begin
                  phase_d = c_PH_IDLE;
                  if (state_q == c_ST_WAITING) begin
                     case (byte_q)
                        8'h31: begin
                           state_d = c_ST_STEP;
                           cnt_d   = 9'd1;
                        end
                        8'h32: begin
                           state_d = c_ST_RUN;
                           tmo_d   = '0;
                        end
                        8'h33: begin
                           state_d = c_ST_SOFT_RESET;
                           cnt_d   = 9'd1;
`ifdef BREAKPOINT_EN
                           bp_valid_d = 1'b0;
`endif
                        end
                        8'h34: begin
                           state_d = c_ST_ARG_RX;
                           cnt_d   = 9'd1;
`ifdef BREAKPOINT_EN
                           arg_bp_d = 1'b0;
`endif
                        end
`ifdef BREAKPOINT_EN
                        8'h35: begin
                           state_d    = c_ST_ARG_RX;
                           cnt_d      = c_ARG_BYTES;
                           arg_bp_d   = 1'b1;
                           bp_valid_d = 1'b0;
                        end
                        8'h36: begin
                           state_d    = c_ST_SENDING;
                           bp_valid_d = 1'b0;
                           status_d   = 8'h05;
                        end
`endif
                        default: begin
                           state_d  = c_ST_UNKNOWN;
                           status_d = 8'hFF;
                        end
                     endcase
                  end else
`ifdef BREAKPOINT_EN
                  if (arg_bp_q) begin
                     bp_d  = PC_WIDTH'({bp_q, byte_q});
                     cnt_d = cnt_q - 9'd1;
                     if (cnt_q == 9'd1) begin
                        bp_valid_d = 1'b1;
                        status_d   = 8'h05;
                        state_d    = c_ST_SENDING;
                     end
                  end else
`endif
                  begin
                     cnt_d   = (byte_q == 8'h00) ? 9'd256 : {1'b0, byte_q};
                     state_d = c_ST_STEP;
                  end
               end
            endcase
         end
         c_ST_STEP: begin
            if (bus.program_finished) begin
               status_d = 8'h01;
               state_d  = c_ST_SENDING;
            end else if (cnt_q == 9'd0) begin
               status_d = 8'h00;
               state_d  = c_ST_SENDING;
            end else begin
               cnt_d = cnt_q - 9'd1;
            end
         end
         c_ST_RUN: begin
            // A breakpoint only counts once the pipeline has advanced
            if (bus.program_finished) begin
               status_d = 8'h01;
               state_d  = c_ST_SENDING;
            end else
`ifdef BREAKPOINT_EN
            if (bp_valid_q && (tmo_q != '0) && (bus.pc == bp_q)) begin
               status_d = 8'h02;
               state_d  = c_ST_SENDING;
            end else
`endif
            if (&tmo_q) begin
               status_d = 8'h03;
               state_d  = c_ST_SENDING;
            end else begin
               tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
            end
         end
         c_ST_SOFT_RESET: begin
            if (cnt_q == c_RST_CYC) begin
               status_d = 8'h04;
               cnt_d    = 9'd0;
               state_d  = c_ST_SENDING;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         c_ST_UNKNOWN: state_d = c_ST_SENDING;
         c_ST_SENDING: begin
            if (bus.data_sent) begin
               state_d = c_ST_WAITING;
            end
         end
         default: state_d = c_ST_WAITING;
      endcase
   end

   // Outputs follow the next state so they line up with state_q
   always_comb begin
      rd_uart_d = (phase_d == c_PH_POP);
      send_d    = (state_d == c_ST_SENDING);
      prst_d    = (state_d == c_ST_INIT) || (state_d == c_ST_SOFT_RESET);
      clk_en_d  = prst_d ||
                  ((state_d == state_q) &&
                   ((state_q == c_ST_STEP) || (state_q == c_ST_RUN)));
   end

   assign bus.rd_uart         = rd_uart_q;
   assign bus.send_signal     = send_q;
   assign bus.status_code     = status_q;
   assign bus.pipeline_clk_en = clk_en_q;
   assign bus.pipeline_reset  = prst_q;
   assign bus.current_state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_cmd_ctrl
// Brief    : Directed vector bench for debug_cmd_ctrl with an RX FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_cmd_ctrl;

   localparam int c_PCW    = 32;
   localparam int c_TOW    = 4;
   localparam int c_RSTC   = 2;
   localparam int c_MAXCYC = 2000;

   // pc_at / pf_at: 0 = never, -1 = applied before the command, k = during k-th enabled cycle
   typedef struct {
      int          nb;
      logic [39:0] bytes;
      int          pc_at;
      logic [31:0] pc_val;
      int          pf_at;
      logic [7:0]  exp_status;
      int          exp_en;
      int          exp_rd;
      int          exp_prst;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b0;

   debug_cmd_ctrl_if #(.PC_WIDTH(c_PCW)) bus_if ();

   debug_cmd_ctrl #(
      .PC_WIDTH      (c_PCW),
      .TIMEOUT_WIDTH (c_TOW),
      .RESET_CYCLES  (c_RSTC)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clock = ~clock;

   logic [7:0] fifo [0:63];
   int         wr_idx  = 0;
   int         rd_idx  = 0;
   int         n_pass  = 0;
   int         n_total = 0;
   vec_t       vt[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic fifo_update();
      bus_if.rx_ready = (rd_idx < wr_idx);
      bus_if.r_data   = (rd_idx < wr_idx) ? fifo[rd_idx] : 8'h00;
   endtask

   task automatic push(input logic [7:0] b);
      fifo[wr_idx] = b;
      wr_idx++;
      fifo_update();
   endtask

   // One clock; the FIFO head advances when the DUT pops
   task automatic tick();
      @(posedge clock);
      #1;
      if (bus_if.rd_uart && (rd_idx < wr_idx)) begin
         rd_idx++;
         fifo_update();
      end
   endtask

   function automatic vec_t mk(input int nb, input logic [39:0] b, input int pc_at,
                               input logic [31:0] pv, input int pf_at, input logic [7:0] st,
                               input int en, input int rd, input int prst);
      vec_t v;
      v.nb = nb; v.bytes = b; v.pc_at = pc_at; v.pc_val = pv; v.pf_at = pf_at;
      v.exp_status = st; v.exp_en = en; v.exp_rd = rd; v.exp_prst = prst;
      return v;
   endfunction

   task automatic wait_init(input string nm);
      int en = 0, prst = 0, rd = 0, cyc = 0;
      while ((bus_if.current_state != 4'd1) && (cyc < 50)) begin
         tick();
         cyc++;
         if (bus_if.current_state != 4'd1) begin
            if (bus_if.pipeline_clk_en) en++;
            if (bus_if.pipeline_reset)  prst++;
            if (bus_if.rd_uart)         rd++;
         end
      end
      chk({nm, " state"}, {28'd0, bus_if.current_state}, 32'd1);
      chk({nm, " clk_en cycles"}, en, c_RSTC);
      chk({nm, " reset cycles"}, prst, c_RSTC);
      chk({nm, " rd pulses"}, rd, 0);
      chk({nm, " idle outputs"}, {bus_if.pipeline_clk_en, bus_if.pipeline_reset, bus_if.send_signal},
          3'b000);
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int en = 0, rd = 0, prst = 0, cyc = 0;
      bit done = 0;
      for (int i = 0; i < v.nb; i++) push(v.bytes[39-8*i -: 8]);
      if (v.pc_at == -1) bus_if.pc = v.pc_val;
      if (v.pf_at == -1) bus_if.program_finished = 1'b1;
      while (!done && (cyc < c_MAXCYC)) begin
         tick();
         cyc++;
         if (bus_if.send_signal) begin
            done = 1;
         end else begin
            if (bus_if.rd_uart)        rd++;
            if (bus_if.pipeline_reset) prst++;
            if (bus_if.pipeline_clk_en) begin
               en++;
               if (en == v.pc_at) bus_if.pc = v.pc_val;
               if (en == v.pf_at) bus_if.program_finished = 1'b1;
            end
         end
      end
      if (!done) begin
         chk({nm, " send_signal timeout"}, 32'd0, 32'd1);
      end else begin
         chk({nm, " status"}, {24'd0, bus_if.status_code}, {24'd0, v.exp_status});
         chk({nm, " clk_en cycles"}, en, v.exp_en);
         chk({nm, " rd pulses"}, rd, v.exp_rd);
         chk({nm, " reset cycles"}, prst, v.exp_prst);
         chk({nm, " state sending"}, {28'd0, bus_if.current_state}, 32'd7);
         tick();
         tick();
         chk({nm, " send hold"}, {23'd0, bus_if.send_signal, bus_if.status_code},
             {23'd0, 1'b1, v.exp_status});
         bus_if.data_sent = 1'b1;
         tick();
         bus_if.data_sent = 1'b0;
         chk({nm, " send release"}, {27'd0, bus_if.send_signal, bus_if.current_state}, {27'd0, 1'b0, 4'd1});
      end
      bus_if.pc = '0;
      bus_if.program_finished = 1'b0;
   endtask

   initial begin
      int cyc;
      int en;
      bus_if.r_data = 8'h00;
      bus_if.rx_ready = 1'b0;
      bus_if.program_finished = 1'b0;
      bus_if.pc = '0;
      bus_if.data_sent = 1'b0;

      #2 reset = 1'b1;
      #1;
      chk("reset values", {bus_if.current_state, bus_if.rd_uart, bus_if.send_signal, bus_if.status_code,
                           bus_if.pipeline_clk_en, bus_if.pipeline_reset},
          {4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      wait_init("init");

      vt.push_back(mk(2, 40'h3405_000000, 0, 0, 0, 8'h00, 5, 2, 0));
      vt.push_back(mk(1, 40'h3100_000000, 0, 0, 0, 8'h00, 1, 1, 0));
      vt.push_back(mk(2, 40'h3400_000000, 0, 0, 0, 8'h00, 256, 2, 0));
      vt.push_back(mk(2, 40'h3403_000000, 0, 0, -1, 8'h01, 0, 2, 0));
      vt.push_back(mk(2, 40'h3408_000000, 0, 0, 3, 8'h01, 3, 2, 0));
      vt.push_back(mk(1, 40'h3200_000000, 0, 0, -1, 8'h01, 0, 1, 0));
      vt.push_back(mk(1, 40'h3200_000000, 0, 0, 10, 8'h01, 10, 1, 0));
      vt.push_back(mk(1, 40'h3200_000000, 0, 0, 0, 8'h03, 15, 1, 0));
      vt.push_back(mk(1, 40'h3300_000000, 0, 0, 0, 8'h04, 2, 1, 2));
      vt.push_back(mk(1, 40'h7A00_000000, 0, 0, 0, 8'hFF, 0, 1, 0));
`ifdef BREAKPOINT_EN
      vt.push_back(mk(5, 40'h3500_000040, 0, 0, 0, 8'h05, 0, 5, 0));
      vt.push_back(mk(1, 40'h3200_000000, 7, 32'h40, 0, 8'h02, 7, 1, 0));
      vt.push_back(mk(1, 40'h3200_000000, 10, 32'h40, 10, 8'h01, 10, 1, 0));
      vt.push_back(mk(1, 40'h3200_000000, -1, 32'h40, 0, 8'h02, 1, 1, 0));
      vt.push_back(mk(1, 40'h3200_000000, 15, 32'h40, 0, 8'h02, 15, 1, 0));
      vt.push_back(mk(1, 40'h3300_000000, 0, 0, 0, 8'h04, 2, 1, 2));
      vt.push_back(mk(1, 40'h3200_000000, -1, 32'h40, 0, 8'h03, 15, 1, 0));
      vt.push_back(mk(5, 40'h3500_000040, 0, 0, 0, 8'h05, 0, 5, 0));
      vt.push_back(mk(1, 40'h3600_000000, 0, 0, 0, 8'h05, 0, 1, 0));
      vt.push_back(mk(1, 40'h3200_000000, -1, 32'h40, 6, 8'h01, 6, 1, 0));
`else
      vt.push_back(mk(5, 40'h3500_000040, 0, 0, 0, 8'hFF, 0, 1, 0));
      vt.push_back(mk(0, 40'h0, 0, 0, 0, 8'hFF, 0, 1, 0));
      vt.push_back(mk(0, 40'h0, 0, 0, 0, 8'hFF, 0, 1, 0));
      vt.push_back(mk(0, 40'h0, 0, 0, 0, 8'hFF, 0, 1, 0));
      vt.push_back(mk(0, 40'h0, 0, 0, 0, 8'hFF, 0, 1, 0));
      vt.push_back(mk(1, 40'h3600_000000, 0, 0, 0, 8'hFF, 0, 1, 0));
      vt.push_back(mk(1, 40'h3200_000000, -1, 32'h40, 6, 8'h01, 6, 1, 0));
`endif
      for (int i = 0; i < vt.size(); i++) run_vec(vt[i], $sformatf("v%0d", i));

      // Reset in the middle of a run
      push(8'h32);
      cyc = 0;
      en  = 0;
      while ((en < 3) && (cyc < 100)) begin
         tick();
         cyc++;
         if (bus_if.pipeline_clk_en) en++;
      end
      chk("run reached", en, 3);
      #3 reset = 1'b1;
      #1;
      chk("reset during run", {bus_if.current_state, bus_if.rd_uart, bus_if.send_signal,
                               bus_if.status_code, bus_if.pipeline_clk_en, bus_if.pipeline_reset},
          {4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
      @(posedge clock);
      #1 reset = 1'b0;
      wait_init("reinit1");

      // Reset while the status dump is pending
      push(8'h7A);
      cyc = 0;
      while (!bus_if.send_signal && (cyc < 100)) begin
         tick();
         cyc++;
      end
      chk("sending reached", {31'd0, bus_if.send_signal}, 32'd1);
      #3 reset = 1'b1;
      #1;
      chk("reset during send", {bus_if.current_state, bus_if.rd_uart, bus_if.send_signal,
                                bus_if.status_code, bus_if.pipeline_clk_en, bus_if.pipeline_reset},
          {4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
      @(posedge clock);
      #1 reset = 1'b0;
      wait_init("reinit2");
      run_vec(mk(1, 40'h7A00_000000, 0, 0, 0, 8'hFF, 0, 1, 0), "post-reset unknown");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
